avalon_led_pio: RTL and testbench
=================================

Name: avalon_led_pio

Overview:
- Parametrised Avalon-MM slave output port driving board LEDs or other GPIO outputs.
- Successor to the fixed 10-bit single-register LED port.
- Adds atomic set, clear and toggle write strobes, a per-bit blink mask and a programmable blink period counter.
- Sits on the system interconnect as a memory-mapped slave; out_port connects to top-level pins.

Parameters:
WIDTH, 10, number of output bits (1..32)
RESET_VALUE, 0, value loaded into DATA on reset (WIDTH bits)
DIV_WIDTH, 24, width of blink period register and counter (1..32)
RESET_PERIOD, 2499999, reset value of BLINK_PERIOD (half-period minus 1, in clk cycles)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
address  input  3  word address within slave
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, qualified by chipselect
writedata  input  32  write data
readdata  output  32  read data, combinational from address, zero-extended
out_port  output  WIDTH  effective output value

Behaviour:
- Write event: chipselect=1 and write_n=0, sampled on posedge clk. Zero wait states; no read strobe is needed.
- Reads are side-effect free. Unused readdata bits are 0. Reads of unmapped addresses 7 and 8-7 return 0.
- Register map. Writes use writedata[WIDTH-1:0] unless stated otherwise.
  - 0 DATA RW: data <= wd. Read returns data.
  - 1 SET W: data <= data | wd. Read returns out_port, the effective value.
  - 2 CLEAR W: data <= data & ~wd. Read returns 0.
  - 3 TOGGLE W: data <= data ^ wd. Read returns 0.
  - 4 BLINK_MASK RW: mask <= wd. Read returns mask.
  - 5 BLINK_PERIOD RW: period <= writedata[DIV_WIDTH-1:0]. The same write also clears the counter and phase. Read returns period.
  - 6 STATUS R: bit0 = phase; bit1 = (mask != 0). Writes are ignored.
- Blink engine:
  - cnt is a DIV_WIDTH-bit counter and runs continuously.
  - If cnt == period: cnt <= 0 and phase <= ~phase. Otherwise cnt <= cnt + 1.
  - Half-period = period+1 cycles. period=0 toggles phase every cycle.
  - A period write takes priority over the counter update in the same cycle: cnt=0, phase=0.
  - If period is written below the current cnt, the wrap is still clean because the counter is reset by that write.
- Output: out_port = data ^ (mask & {WIDTH{phase}}).
  - Combinational from flops only; no combinational path from bus inputs.
  - A write is visible on out_port in the cycle after the write edge (1-cycle latency).
  - A masked bit blinks around its DATA value: it shows DATA when phase=0 and ~DATA when phase=1.
- Only one register is written per cycle, so SET, CLEAR and TOGGLE to DATA are never simultaneous.
- Reset (asynchronous, any time including mid-blink) sets:
  - data=RESET_VALUE, mask=0, period=RESET_PERIOD, cnt=0, phase=0.
  - Therefore out_port=RESET_VALUE and readdata follows the address decode.

Decomposition:
- Package avalon_led_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_SET=1, ADDR_CLR=2, ADDR_TGL=3, ADDR_MASK=4, ADDR_PERIOD=5, ADDR_STATUS=6.
  - STATUS bit indices.
- One sub-module is natural: blink_divider, holding the counter, period compare and phase flop, with ports clk, reset_n, period, restart, phase.
- Register file and read mux stay in the top module.

Test Plan:
- Reset with WIDTH=10, RESET_VALUE=10'h155 -> out_port=0x155; read addr0 = 0x00000155; read addr5 = RESET_PERIOD; read addr6 = 0.
- Write DATA=0x0F0, then SET 0x003, then CLEAR 0x010, then TOGGLE 0x201 -> DATA reads 0x0F3, then 0x0E3, then 0x2E2. Each value appears on out_port one cycle after its write edge.
- Write PERIOD=3, MASK=0x001, DATA=0 -> out_port[0] is 0 for 4 cycles, then 1 for 4 cycles, repeating. Bits 9:1 stay 0. STATUS bit0 tracks phase.
- PERIOD=0, MASK=0x3FF, DATA=0x0AA -> out_port alternates 0x0AA and 0x355 every cycle.
- Mid-blink, with phase=1 and cnt=2, write PERIOD=5 -> next cycle cnt=0 and phase=0. The next toggle occurs 6 cycles later.
- Assert reset_n low asynchronously mid-cycle while blinking -> out_port returns to RESET_VALUE immediately. After release, mask=0 and no blinking occurs. chipselect=0 with write_n=0 leaves all registers unchanged.

Source files
------------

// File: rtl/avalon_led_pio_pkg.sv
// Shared register map and STATUS bit layout for the Avalon LED/GPIO output port.
package avalon_led_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_TGL    = 3'd3;
    localparam logic [2:0] ADDR_MASK   = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_MASK_BIT  = 1;

endpackage

// File: rtl/avalon_led_pio_blink_divider.sv
// Free-running half-period counter; phase flips each time cnt reaches period.
module blink_divider #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic                 restart,
    output logic                 phase
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 phase_q, phase_d;

    // restart wins so a shortened period can never be skipped past by cnt
    always_comb begin
        cnt_d   = cnt_q + DIV_WIDTH'(1);
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/avalon_led_pio.sv
// Avalon-MM output port with set/clear/toggle strobes and a per-bit blink engine.
module avalon_led_pio
    import avalon_led_pio_pkg::*;
#(
    parameter int                 WIDTH        = 10,
    parameter logic [WIDTH-1:0]   RESET_VALUE  = '0,
    parameter int                 DIV_WIDTH    = 24,
    parameter int unsigned        RESET_PERIOD = 2499999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]     data_q, data_d;
    logic [WIDTH-1:0]     mask_q, mask_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic                 wr_en;
    logic                 period_wr;
    logic                 phase;
    logic [WIDTH-1:0]     wd;
    logic                 unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign period_wr = wr_en && (address == ADDR_PERIOD);
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d   = wd;
                ADDR_SET:    data_d   = data_q | wd;
                ADDR_CLR:    data_d   = data_q & ~wd;
                ADDR_TGL:    data_d   = data_q ^ wd;
                ADDR_MASK:   mask_d   = wd;
                ADDR_PERIOD: period_d = writedata[DIV_WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            mask_q   <= '0;
            period_q <= DIV_WIDTH'(RESET_PERIOD);
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end

    blink_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (period_wr),
        .phase   (phase)
    );

    // Masked bits invert around DATA while phase is high
    assign out_port = data_q ^ (mask_q & {WIDTH{phase}});

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_SET:    readdata = 32'(out_port);
            ADDR_MASK:   readdata = 32'(mask_q);
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT] = phase;
                readdata[STATUS_MASK_BIT]  = |mask_q;
            end
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avalon_led_pio.sv
// Directed bench for avalon_led_pio with WIDTH=10, RESET_VALUE=0x155.
module tb_avalon_led_pio;

    localparam int          W  = 10;
    localparam logic [9:0]  RV = 10'h155;
    localparam logic [31:0] RP = 32'd2499999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [W-1:0] out_port;

    int total = 0;
    int bad = 0;

    avalon_led_pio #(
        .WIDTH        (W),
        .RESET_VALUE  (RV),
        .DIV_WIDTH    (24),
        .RESET_PERIOD (2499999)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic test_reset;
        logic [2:0]  a [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [31:0] e [5] = '{32'h155, 32'h0, RP, 32'h0, 32'h0};
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        total++;
        if (out_port !== RV) begin
            bad++; $display("FAIL reset_out actual=%h required=%h", out_port, RV);
        end
        for (int i = 0; i < 5; i++) begin
            address = a[i]; #1;
            total++;
            if (readdata !== e[i]) begin
                bad++; $display("FAIL reset_read addr=%0d actual=%h required=%h", a[i], readdata, e[i]);
            end
        end
    endtask

    task automatic test_regs;
        logic [2:0]  a  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [31:0] d  [4] = '{32'hFFFF_F0F0, 32'h003, 32'h010, 32'h201};
        logic [9:0]  e  [4] = '{10'h0F0, 10'h0F3, 10'h0E3, 10'h2E2};
        logic [9:0]  prev = RV;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            address = a[i]; chipselect = 1'b1; write_n = 1'b0; writedata = d[i];
            #1;
            total++;
            if (out_port !== prev) begin
                bad++; $display("FAIL pre_edge_out step=%0d actual=%h required=%h", i, out_port, prev);
            end
            @(negedge clk);
            chipselect = 1'b0; write_n = 1'b1; writedata = '0;
            total++;
            if (out_port !== e[i]) begin
                bad++; $display("FAIL post_edge_out step=%0d actual=%h required=%h", i, out_port, e[i]);
            end
            address = 3'd0; #1;
            total++;
            if (readdata !== {22'd0, e[i]}) begin
                bad++; $display("FAIL data_read step=%0d actual=%h required=%h", i, readdata, e[i]);
            end
            prev = e[i];
        end
        for (int i = 2; i < 4; i++) begin
            address = 3'(i); #1;
            total++;
            if (readdata !== 32'h0) begin
                bad++; $display("FAIL wo_read addr=%0d actual=%h required=0", i, readdata);
            end
        end
    endtask

    task automatic test_blink;
        logic [31:0] ph;
        wr(3'd4, 32'h001);
        wr(3'd0, 32'h000);
        wr(3'd5, 32'd3);
        for (int k = 0; k < 16; k++) begin
            ph = 32'((k / 4) % 2);
            total++;
            if (out_port !== ph[9:0]) begin
                bad++; $display("FAIL blink_out k=%0d actual=%h required=%h", k, out_port, ph[9:0]);
            end
            address = 3'd6; #1;
            total++;
            if (readdata !== (32'd2 | ph)) begin
                bad++; $display("FAIL blink_status k=%0d actual=%h required=%h", k, readdata, 32'd2 | ph);
            end
            @(negedge clk);
        end
        address = 3'd4; #1;
        total++;
        if (readdata !== 32'h001) begin
            bad++; $display("FAIL mask_read actual=%h required=%h", readdata, 32'h001);
        end
        address = 3'd5; #1;
        total++;
        if (readdata !== 32'd3) begin
            bad++; $display("FAIL period_read actual=%h required=%h", readdata, 32'd3);
        end
    endtask

    task automatic test_fast;
        logic [9:0] e;
        wr(3'd0, 32'h0AA);
        wr(3'd4, 32'h3FF);
        wr(3'd5, 32'd0);
        for (int k = 0; k < 8; k++) begin
            e = (k % 2 == 1) ? 10'h355 : 10'h0AA;
            total++;
            if (out_port !== e) begin
                bad++; $display("FAIL fast_out k=%0d actual=%h required=%h", k, out_port, e);
            end
            address = 3'd1; #1;
            total++;
            if (readdata !== {22'd0, e}) begin
                bad++; $display("FAIL set_read_eff k=%0d actual=%h required=%h", k, readdata, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart;
        logic [9:0] e;
        wr(3'd5, 32'd3);
        repeat (5) @(negedge clk);
        total++;
        if (out_port !== 10'h355) begin
            bad++; $display("FAIL pre_restart_out actual=%h required=%h", out_port, 10'h355);
        end
        wr(3'd5, 32'd5);
        for (int j = 0; j < 7; j++) begin
            e = (j == 6) ? 10'h355 : 10'h0AA;
            total++;
            if (out_port !== e) begin
                bad++; $display("FAIL restart_out j=%0d actual=%h required=%h", j, out_port, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (out_port !== RV) begin
            bad++; $display("FAIL async_reset_out actual=%h required=%h", out_port, RV);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total++;
            if (out_port !== RV) begin
                bad++; $display("FAIL no_blink k=%0d actual=%h required=%h", k, out_port, RV);
            end
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b0; writedata = 32'h3FF; address = 3'd0;
        @(negedge clk); address = 3'd4;
        @(negedge clk); address = 3'd5;
        @(negedge clk); write_n = 1'b1; writedata = '0;
        wr(3'd6, 32'hFFFF_FFFF);
        address = 3'd0; #1;
        total++;
        if (readdata !== 32'h155) begin
            bad++; $display("FAIL nocs_data actual=%h required=%h", readdata, 32'h155);
        end
        address = 3'd4; #1;
        total++;
        if (readdata !== 32'h0) begin
            bad++; $display("FAIL nocs_mask actual=%h required=0", readdata);
        end
        address = 3'd5; #1;
        total++;
        if (readdata !== RP) begin
            bad++; $display("FAIL nocs_period actual=%h required=%h", readdata, RP);
        end
        address = 3'd6; #1;
        total++;
        if (readdata !== 32'h0) begin
            bad++; $display("FAIL status_after_reset actual=%h required=0", readdata);
        end
        total++;
        if (out_port !== RV) begin
            bad++; $display("FAIL final_out actual=%h required=%h", out_port, RV);
        end
    endtask

    initial begin
        test_reset;
        test_regs;
        test_blink;
        test_fast;
        test_restart;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
